crc32_dibit: RTL and testbench

Streaming Ethernet CRC-32 (FCS) generator that consumes one 2-bit RMII dibit per clock and holds a running checksum. It sits beside the Ethernet frame packer. The packer feeds it every transmitted dibit from destination address through payload. It then serialises `axiod` onto the PHY as the frame check sequence.

---
 rtl/crc32_dibit.sv | 82 ++++++++
 tb/tb_crc32_dibit.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/crc32_dibit.sv
// ---------------------------------------------------------------------------
// crc32_dibit
//   Streaming Ethernet CRC-32 (FCS) generator. It absorbs one 2-bit RMII
//   dibit per clock, earlier bit in axiid[0], and keeps a running checksum.
//   The checksum uses the reflected polynomial 0xEDB88320 and starts from
//   0xFFFFFFFF.
//
// Ports
//   clk    in   1   system clock; all state updates on the rising edge
//   rst    in   1   asynchronous active-high reset (crc=FFFFFFFF, axiov=0)
//   axiiv  in   1   dibit valid; axiid is absorbed on this edge
//   axiid  in   2   data dibit, axiid[0] is the earlier bit on the wire
//   axiov  out  1   sticky: at least one dibit absorbed since reset
//   axiod  out  32  inverted CRC, byte-swapped so that axiod[31:24] is the
//                   first FCS byte and axiod[24] the first FCS bit
// ---------------------------------------------------------------------------
module crc32_dibit (
  input  logic        clk,
  input  logic        rst,
  input  logic        axiiv,
  input  logic [1:0]  axiid,
  output logic        axiov,
  output logic [31:0] axiod
);

  localparam logic [31:0] POLY_REFL = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT  = 32'hFFFFFFFF;

  logic [31:0] crc_q;
  logic [31:0] crc_d;
  logic        axiov_q;
  logic        axiov_d;

  // Intermediate value after the first (earlier) bit of the dibit.
  logic [31:0] crc_bit0;
  logic [31:0] crc_bit1;
  logic [31:0] fcs;

  // Two LSB-first shift steps chained combinationally, axiid[0] first.
  always_comb begin
    crc_bit0 = crc_q >> 1;
    if (crc_q[0] ^ axiid[0]) begin
      crc_bit0 = crc_bit0 ^ POLY_REFL;
    end

    crc_bit1 = crc_bit0 >> 1;
    if (crc_bit0[0] ^ axiid[1]) begin
      crc_bit1 = crc_bit1 ^ POLY_REFL;
    end

    crc_d   = crc_q;
    axiov_d = axiov_q;
    if (axiiv) begin
      crc_d   = crc_bit1;
      axiov_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_q   <= CRC_INIT;
      axiov_q <= 1'b0;
    end else begin
      crc_q   <= crc_d;
      axiov_q <= axiov_d;
    end
  end

  // Output depends only on the flops: inversion plus byte swap. The swap
  // puts the least significant CRC byte (first on the wire) in [31:24].
  assign fcs = ~crc_q;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_byte_swap
      assign axiod[8*gi +: 8] = fcs[8*(3-gi) +: 8];
    end
  endgenerate

  assign axiov = axiov_q;

endmodule

// File: tb/tb_crc32_dibit.sv
module tb_crc32_dibit;

  logic        clk;
  logic        rst;
  logic        axiiv;
  logic [1:0]  axiid;
  logic        axiov;
  logic [31:0] axiod;

  int vectors;
  int miscompares;

  byte check_str [9];
  byte fcs_bytes [4];

  crc32_dibit dut (
    .clk   (clk),
    .rst   (rst),
    .axiiv (axiiv),
    .axiid (axiid),
    .axiov (axiov),
    .axiod (axiod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected)
      else begin
        miscompares++;
        $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
    $display("vector %0d %s: observed %h expected %h", vectors, tag, observed, expected);
  endtask

  // Present one dibit for exactly one rising edge; called at a falling edge,
  // returns at the next falling edge with axiiv dropped.
  task automatic send_dibit(input logic [1:0] d);
    axiiv = 1'b1;
    axiid = d;
    @(negedge clk);
    axiiv = 1'b0;
    axiid = 2'b00;
  endtask

  // LSB-first: bits [1:0] go first, written as {b1,b0}.
  task automatic send_byte(input byte b, input bit gaps);
    logic [7:0] v;
    v = b;
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        int n;
        n = $urandom_range(0, 3);
        for (int g = 0; g < n; g++) @(negedge clk);
      end
      send_dibit({v[2*i+1], v[2*i]});
    end
  endtask

  task automatic send_check_string(input bit gaps);
    for (int k = 0; k < 9; k++) send_byte(check_str[k], gaps);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst         = 1'b1;
    axiiv       = 1'b0;
    axiid       = 2'b00;
    check_str   = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    fcs_bytes   = '{8'h26, 8'h39, 8'hF4, 8'hCB};

    // Reset state, held and then released for 10 idle cycles.
    #2;
    chk("rst_during_axiod", axiod, 32'h00000000);
    chk("rst_during_axiov", {31'd0, axiov}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("idle_axiod", axiod, 32'h00000000);
      chk("idle_axiov", {31'd0, axiov}, 32'd0);
    end

    // Single dibit 00: FFFFFFFF -> 92477CDF -> A49B3D4F, ~ = 5B64C2B0.
    send_dibit(2'b00);
    chk("single00_axiov", {31'd0, axiov}, 32'd1);
    chk("single00_axiod", axiod, 32'hB0C2645B);
    // Idle cycles must hold the value.
    @(negedge clk);
    @(negedge clk);
    chk("single00_hold", axiod, 32'hB0C2645B);
    chk("single00_hold_v", {31'd0, axiov}, 32'd1);

    // Check value "123456789", back to back.
    pulse_reset();
    chk("pre_check_axiov", {31'd0, axiov}, 32'd0);
    send_check_string(1'b0);
    chk("check_axiod", axiod, 32'h2639F4CB);
    chk("check_axiov", {31'd0, axiov}, 32'd1);

    // Same stream with random gaps.
    pulse_reset();
    send_check_string(1'b1);
    chk("gaps_axiod", axiod, 32'h2639F4CB);
    chk("gaps_axiov", {31'd0, axiov}, 32'd1);

    // Residue after data plus its own FCS.
    pulse_reset();
    send_check_string(1'b0);
    for (int k = 0; k < 4; k++) send_byte(fcs_bytes[k], 1'b0);
    chk("residue_axiod", axiod, 32'h1CDF4421);

    // Reset asserted mid-cycle, mid-stream: must clear without a clock edge.
    pulse_reset();
    for (int k = 0; k < 10; k++) send_dibit(2'(k));
    chk("midstream_v_before", {31'd0, axiov}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_axiod", axiod, 32'h00000000);
    chk("async_rst_axiov", {31'd0, axiov}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("after_rst_axiov", {31'd0, axiov}, 32'd0);
    chk("after_rst_axiod", axiod, 32'h00000000);
    send_check_string(1'b0);
    chk("after_rst_check", axiod, 32'h2639F4CB);

    // Simultaneous reset and valid: reset wins, dibit discarded.
    rst   = 1'b1;
    axiiv = 1'b1;
    axiid = 2'b11;
    @(negedge clk);
    rst   = 1'b0;
    axiiv = 1'b0;
    axiid = 2'b00;
    @(negedge clk);
    chk("rst_wins_axiov", {31'd0, axiov}, 32'd0);
    chk("rst_wins_axiod", axiod, 32'h00000000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
